// File: rtl/mux_rr_n_1.sv
// N:1 channel multiplexer with fixed-select and round-robin modes, feeding a
// single registered output stage with valid/ready handshake.
module mux_rr_n_1 #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned SEL_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] a_flat,
    input  logic [CHANNELS-1:0]       a_valid,
    output logic [CHANNELS-1:0]       a_ready,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    output logic [WIDTH-1:0]          y,
    output logic                      y_valid,
    input  logic                      y_ready,
    output logic [SEL_W-1:0]          y_ch
);

    logic [WIDTH-1:0] r_y;
    logic [SEL_W-1:0] r_y_ch;
    logic             r_y_valid;
    logic [SEL_W-1:0] r_ptr;

    logic             w_out_ready;
    logic             w_grant;
    logic [SEL_W-1:0] w_grant_idx;
    logic             w_xfer;
    logic [WIDTH-1:0] w_data;
    int unsigned      w_dist;
    int unsigned      w_best_dist;

    assign w_out_ready = !r_y_valid || y_ready;
    assign w_xfer      = w_grant && w_out_ready;

    // Grant selection. In round-robin mode the winner is the valid channel at the
    // smallest forward distance from ptr+1, which equals the wrap-around search order.
    always_comb begin
        w_grant     = 1'b0;
        w_grant_idx = '0;
        w_dist      = 0;
        w_best_dist = CHANNELS;
        if (!mode) begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                if (32'(sel) == k && a_valid[k]) begin
                    w_grant     = 1'b1;
                    w_grant_idx = SEL_W'(k);
                end
            end
        end else begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                w_dist = (k + CHANNELS - 1 - 32'(r_ptr)) % CHANNELS;
                if (a_valid[k] && w_dist < w_best_dist) begin
                    w_best_dist = w_dist;
                    w_grant     = 1'b1;
                    w_grant_idx = SEL_W'(k);
                end
            end
        end
    end

    always_comb begin
        w_data = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (32'(w_grant_idx) == k) begin
                w_data = a_flat[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        a_ready = '0;
        if (w_xfer && !rst) begin
            a_ready = CHANNELS'(1) << w_grant_idx;
        end
    end

    // ptr resets to the last channel so the first round-robin search starts at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y       <= '0;
            r_y_ch    <= '0;
            r_y_valid <= 1'b0;
            r_ptr     <= SEL_W'(CHANNELS - 1);
        end else if (w_xfer) begin
            r_y       <= w_data;
            r_y_ch    <= w_grant_idx;
            r_y_valid <= 1'b1;
            r_ptr     <= w_grant_idx;
        end else if (y_ready) begin
            r_y_valid <= 1'b0;
        end
    end

    assign y       = r_y;
    assign y_ch    = r_y_ch;
    assign y_valid = r_y_valid;

endmodule

// File: tb/tb_mux_rr_n_1.sv
// Bench for mux_rr_n_1: an 8-channel instance checked every cycle against a
// behavioural model plus directed literals, and a 6-channel instance for select overflow.
module tb_mux_rr_n_1;

    logic        clk;
    logic        rst;
    logic [63:0] a_flat;
    logic [7:0]  a_valid;
    logic [7:0]  a_ready;
    logic [2:0]  sel;
    logic        mode;
    logic [7:0]  y;
    logic        y_valid;
    logic        y_ready;
    logic [2:0]  y_ch;

    logic        rst6;
    logic [47:0] flat6;
    logic [5:0]  valid6;
    logic [5:0]  ready6;
    logic [2:0]  sel6;
    logic        mode6;
    logic [7:0]  y6;
    logic        y_valid6;
    logic        y_ready6;
    logic [2:0]  y_ch6;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state for the 8-channel instance.
    bit       m_init  = 0;
    bit       m_valid = 0;
    bit [7:0] m_y     = 0;
    int       m_ch    = 0;
    int       m_ptr   = 7;

    logic [7:0] exp_word;

    mux_rr_n_1 #(.WIDTH(8), .CHANNELS(8), .SEL_W(3)) u_dut8 (
        .clk     (clk),
        .rst     (rst),
        .a_flat  (a_flat),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .sel     (sel),
        .mode    (mode),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .y_ch    (y_ch)
    );

    mux_rr_n_1 #(.WIDTH(8), .CHANNELS(6), .SEL_W(3)) u_dut6 (
        .clk     (clk),
        .rst     (rst6),
        .a_flat  (flat6),
        .a_valid (valid6),
        .a_ready (ready6),
        .sel     (sel6),
        .mode    (mode6),
        .y       (y6),
        .y_valid (y_valid6),
        .y_ready (y_ready6),
        .y_ch    (y_ch6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    // Per-cycle model compare; inputs only change just after posedge.
    always @(negedge clk) begin
        bit         orr;
        bit         g;
        int         c;
        int         k;
        logic [7:0] exp_ready;
        if (m_init) begin
            chk("model y_valid", 32'(y_valid), 32'(m_valid));
            chk("model y", 32'(y), 32'(m_y));
            chk("model y_ch", 32'(y_ch), m_ch);
        end
        orr = !m_valid || y_ready;
        g   = 0;
        c   = 0;
        if (!mode) begin
            if (a_valid[sel]) begin
                g = 1;
                c = int'(sel);
            end
        end else begin
            for (int s = 1; s <= 8; s++) begin
                k = (m_ptr + s) % 8;
                if (!g && a_valid[k]) begin
                    g = 1;
                    c = k;
                end
            end
        end
        exp_ready = (rst || !orr || !g) ? 8'h00 : 8'(1 << c);
        if (m_init || rst) chk("model a_ready", 32'(a_ready), 32'(exp_ready));
        if (rst) begin
            m_init  = 1;
            m_valid = 0;
            m_y     = 0;
            m_ch    = 0;
            m_ptr   = 7;
        end else if (m_init) begin
            if (g && orr) begin
                m_y     = a_flat[c*8 +: 8];
                m_ch    = c;
                m_valid = 1;
                m_ptr   = c;
            end else if (y_ready) begin
                m_valid = 0;
            end
        end
    end

    initial begin
        rst     = 1;
        mode    = 1;
        sel     = 0;
        a_valid = 8'hFF;
        y_ready = 1;
        for (int k = 0; k < 8; k++) a_flat[k*8 +: 8] = 8'hA0 | 8'(k);
        rst6     = 1;
        mode6    = 0;
        sel6     = 0;
        valid6   = 0;
        y_ready6 = 0;
        for (int k = 0; k < 6; k++) flat6[k*8 +: 8] = 8'h60 | 8'(k);

        // Reset state, with every channel valid and rst still high.
        step();
        look();
        chk("reset y_valid", 32'(y_valid), 0);
        chk("reset y", 32'(y), 0);
        chk("reset y_ch", 32'(y_ch), 0);
        chk("reset a_ready", 32'(a_ready), 0);

        // Fixed select of channel 5.
        step();
        rst  = 0;
        mode = 0;
        sel  = 5;
        look();
        chk("fixed a_ready", 32'(a_ready), 32'h20);
        step();
        a_valid = 8'h00;
        look();
        chk("fixed y", 32'(y), 32'hA5);
        chk("fixed y_ch", 32'(y_ch), 5);
        chk("fixed y_valid", 32'(y_valid), 1);

        // Round-robin sweep after reset.
        step();
        rst = 1;
        step();
        rst     = 0;
        mode    = 1;
        a_valid = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            step();
            look();
            chk("rr sweep y_ch", 32'(y_ch), 32'(i % 8));
        end

        // Force ptr = 2 with a fixed transfer, then wrap between channels 7 and 2.
        step();
        mode = 0;
        sel  = 2;
        step();
        mode    = 1;
        a_valid = 8'h84;
        look();
        chk("fixed ch2 y_ch", 32'(y_ch), 2);
        step();
        look();
        chk("wrap y_ch 7", 32'(y_ch), 7);
        step();
        look();
        chk("wrap y_ch 2", 32'(y_ch), 2);
        step();
        look();
        chk("wrap y_ch 7b", 32'(y_ch), 7);

        // Back-pressure: ch2 word (A2) held while inputs churn.
        step();
        y_ready = 0;
        a_valid = 8'hFF;
        for (int j = 0; j < 3; j++) begin
            look();
            chk("hold a_ready", 32'(a_ready), 0);
            chk("hold y", 32'(y), 32'hA2);
            chk("hold y_ch", 32'(y_ch), 2);
            chk("hold y_valid", 32'(y_valid), 1);
            step();
            a_flat = a_flat ^ {$urandom(), $urandom()};
        end
        y_ready = 1;
        look();
        chk("release a_ready", 32'(a_ready), 32'h08);
        exp_word = a_flat[31:24];
        step();
        look();
        chk("release y_ch", 32'(y_ch), 3);
        chk("release y", 32'(y), 32'(exp_word));

        // Drain with no grant: y_valid drops, y and y_ch retained.
        exp_word = a_flat[39:32];
        step();
        a_valid = 8'h00;
        look();
        chk("drain a_ready", 32'(a_ready), 0);
        step();
        look();
        chk("drain y_valid", 32'(y_valid), 0);
        chk("drain y_ch", 32'(y_ch), 4);
        chk("drain y", 32'(y), 32'(exp_word));

        // Reset while a word is held under back-pressure.
        step();
        a_valid = 8'h10;
        step();
        y_ready = 0;
        a_valid = 8'h00;
        look();
        chk("pre-rst y_valid", 32'(y_valid), 1);
        chk("pre-rst y_ch", 32'(y_ch), 4);
        step();
        rst = 1;
        step();
        rst     = 0;
        a_valid = 8'h60;
        y_ready = 1;
        look();
        chk("post-rst y_valid", 32'(y_valid), 0);
        chk("post-rst y", 32'(y), 0);
        chk("post-rst y_ch", 32'(y_ch), 0);
        chk("post-rst a_ready", 32'(a_ready), 32'h20);
        step();
        look();
        chk("post-rst y_ch 5", 32'(y_ch), 5);

        // Single valid channel is granted every cycle.
        step();
        a_valid = 8'h08;
        for (int i = 0; i < 3; i++) begin
            step();
            look();
            chk("single y_ch", 32'(y_ch), 3);
            chk("single y_valid", 32'(y_valid), 1);
        end

        // Random traffic, checked by the model only.
        for (int n = 0; n < 300; n++) begin
            step();
            rst     = ($urandom_range(0, 31) == 0);
            mode    = 1'($urandom_range(0, 1));
            sel     = 3'($urandom_range(0, 7));
            a_valid = 8'($urandom());
            y_ready = ($urandom_range(0, 3) != 0);
            a_flat  = {$urandom(), $urandom()};
        end
        step();
        rst     = 0;
        a_valid = 8'h00;

        // Six-channel instance: select beyond the channel count grants nothing.
        step();
        rst6     = 0;
        mode6    = 0;
        sel6     = 1;
        valid6   = 6'h3F;
        y_ready6 = 1;
        step();
        sel6     = 7;
        y_ready6 = 0;
        look();
        chk("ch6 y_valid", 32'(y_valid6), 1);
        chk("ch6 y_ch", 32'(y_ch6), 1);
        chk("ch6 y", 32'(y6), 32'h61);
        chk("ch6 a_ready held", 32'(ready6), 0);
        step();
        look();
        chk("ch6 y_valid held", 32'(y_valid6), 1);
        step();
        y_ready6 = 1;
        look();
        chk("ch6 a_ready sel7", 32'(ready6), 0);
        step();
        sel6 = 6;
        look();
        chk("ch6 y_valid drop", 32'(y_valid6), 0);
        chk("ch6 y_ch kept", 32'(y_ch6), 1);
        chk("ch6 a_ready sel6", 32'(ready6), 0);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_rr_n_1.md
MUX_RR_N_1 -- requirements
Module: mux_rr_n_1

Interface
REQ-001 Parameter WIDTH, default 8, data bits per channel.
REQ-002 Parameter CHANNELS, default 8, number of input channels (2..64).
REQ-003 Parameter SEL_W, default 3, select/channel-index width; SHALL equal ceil(log2(CHANNELS)).
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port a_flat  input  CHANNELS*WIDTH  channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 Port a_valid  input  CHANNELS  per-channel data-valid.
REQ-008 Port a_ready  output  CHANNELS  per-channel accept strobe; at most one bit high.
REQ-009 Port sel  input  SEL_W  channel select in fixed mode.
REQ-010 Port mode  input  1  0 = fixed select, 1 = round-robin over valid channels.
REQ-011 Port y  output  WIDTH  registered output data.
REQ-012 Port y_valid  output  1  y holds a word.
REQ-013 Port y_ready  input  1  downstream accepts y this cycle.
REQ-014 Port y_ch  output  SEL_W  index of the channel that supplied y.

Function
REQ-015 out_ready = !y_valid || y_ready, combinational; a grant is made only when out_ready = 1.
REQ-016 Fixed mode: grant channel sel iff a_valid[sel] = 1 and sel < CHANNELS; sel >= CHANNELS grants nothing.
REQ-017 RR mode: grant the first channel with a_valid high, searching from (ptr+1) mod CHANNELS upward with wrap-around.
REQ-018 ptr updates to the granted index only on a transfer (grant and out_ready); fixed-mode transfers also update ptr.
REQ-019 a_ready[k] = 1 only for the granted channel k while out_ready = 1; all bits 0 otherwise; combinational from current inputs and state.
REQ-020 On transfer, y <= a_flat slice k, y_ch <= k, y_valid <= 1 at the next edge; latency 1 cycle; sustained throughput 1 word per cycle.
REQ-021 y_valid = 1 and y_ready = 0: y, y_ch, y_valid, ptr held; no a_ready asserted.
REQ-022 y_valid = 1, y_ready = 1, no grant: y_valid <= 0; y and y_ch retain their last value.
REQ-023 y_valid = 1, y_ready = 1, grant present: new word loaded in the same edge (no bubble).
REQ-024 A mode or sel change takes effect in the same cycle's grant evaluation; ptr is not cleared by a mode change.
REQ-025 Single valid channel in RR mode: that channel is granted every cycle.
REQ-026 No a_valid high: no grant, ptr unchanged.

Reset
REQ-027 rst = 1 at an edge: y = 0, y_ch = 0, y_valid = 0, ptr = CHANNELS-1 (first RR search begins at channel 0).
REQ-028 rst dominates all other inputs; a_ready SHALL be all-zero while rst = 1; a word held in y at reset is discarded.

Verification
REQ-029 Fixed mode, sel = 5, a_valid = 8'hFF, ch5 data = 8'hA5, y_ready = 1 -> a_ready = 8'h20; next cycle y = 8'hA5, y_ch = 5, y_valid = 1.
REQ-030 RR mode after reset, a_valid = 8'hFF, y_ready = 1 -> y_ch sequence 0,1,2,...,7,0 on consecutive cycles.
REQ-031 RR mode, a_valid = 8'b1000_0100, ptr = 2 -> grant ch7, then ch2, then ch7 (wrap-around).
REQ-032 y_valid = 1, y_ready held 0 for 3 cycles with new channel data changing -> y, y_ch stable, a_ready = 0; y_ready = 1 -> next word loads same cycle.
REQ-033 Fixed mode, CHANNELS = 6 instance, sel = 7 -> a_ready = 0, y_valid drops to 0 after pending word accepted.
REQ-034 rst asserted while y_valid = 1 and y_ready = 0 -> next cycle y_valid = 0, y = 0, y_ch = 0; first RR grant afterwards is lowest valid channel.
